pulse_train_gen: RTL and testbench

Programmable strobe source for the game's timing chain. On a start request it emits a fixed number of single-cycle `pulseOut` strobes, one every `period` clock cycles. It then reports completion with a one-cycle `done`. Its `pulseOut` is the `pulseIn` consumed by downstream pulse counters/dividers; it also paces LED flash sequences.

---
 rtl/game_timing_pkg.sv | 25 ++
 rtl/period_counter.sv | 41 ++++
 rtl/pulse_train_gen.sv | 145 ++++++++++++++
 tb/tb_pulse_train_gen.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/game_timing_pkg.sv
// Shared timing definitions for the game's timing chain.
// - pt_state_e: pulse_train_gen FSM states (2-bit encoding).
// - CLK_FREQ_HZ and derived TICK_* periods, handed to pulse_train_gen's
//   period operand by its instantiators and used by downstream counters.
package game_timing_pkg;

  typedef enum logic [1:0] {
    PT_IDLE = 2'd0,
    PT_RUN  = 2'd1,
    PT_DONE = 2'd2
  } pt_state_e;

  localparam int unsigned CLK_FREQ_HZ = 100_000_000;

  localparam int unsigned TICK_1MS   = CLK_FREQ_HZ / 1000;
  localparam int unsigned TICK_10MS  = CLK_FREQ_HZ / 100;
  localparam int unsigned TICK_100MS = CLK_FREQ_HZ / 10;
  localparam int unsigned TICK_1S    = CLK_FREQ_HZ;

  // Clock cycles in a whole number of milliseconds.
  function automatic int unsigned ticks_for_ms(input int unsigned ms);
    return ms * TICK_1MS;
  endfunction

endpackage

// File: rtl/period_counter.sv
// Cycle counter for pulse_train_gen.
// Ports:
//   Clk    - clock, rising edge
//   Rst    - synchronous active-low reset, clears the count
//   clr    - force the count to zero (priority over en)
//   en     - advance the count; it wraps to zero on terminal count
//   period - latched period P (must be nonzero while en is high)
//   tc     - terminal count, high when the count equals P-1
module period_counter #(
  parameter int unsigned PERIOD_W = 27
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                clr,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tc
);

  logic [PERIOD_W-1:0] cyc_q, cyc_d;

  assign tc = (cyc_q == (period - PERIOD_W'(1)));

  always_comb begin
    cyc_d = cyc_q;
    if (clr) begin
      cyc_d = '0;
    end else if (en) begin
      cyc_d = tc ? '0 : cyc_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable strobe source: on an accepted start it emits `count`
// single-cycle strobes on pulseOut, one every `period` cycles, then a
// one-cycle done. Operands are latched at start; abort cancels silently.
// Ports:
//   Clk, Rst  - clock (rising edge), synchronous active-low reset
//   start     - request a train, sampled only in IDLE
//   period    - cycles between strobes
//   count     - number of strobes
//   abort     - cancel a train in RUN or DONE (no done is produced)
//   pulseOut  - registered single-cycle strobe
//   busy      - registered, high while a train is in RUN or DONE
//   done      - registered one-cycle completion flag
module pulse_train_gen
  import game_timing_pkg::*;
#(
  parameter int unsigned PERIOD_W = 27,
  parameter int unsigned COUNT_W  = 7
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                start,
  input  logic [PERIOD_W-1:0] period,
  input  logic [COUNT_W-1:0]  count,
  input  logic                abort,
  output logic                pulseOut,
  output logic                busy,
  output logic                done
);

  pt_state_e           state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [COUNT_W-1:0]  rem_q, rem_d;
  logic                pulse_q, pulse_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic cnt_clr;
  logic cnt_en;
  logic tc;
  logic accept;
  logic empty_train;

  // abort beats a simultaneous start even though abort alone is a no-op in IDLE.
  assign accept      = (state_q == PT_IDLE) && start && !abort;
  assign empty_train = (period == '0) || (count == '0);

  period_counter #(
    .PERIOD_W (PERIOD_W)
  ) u_period_counter (
    .Clk    (Clk),
    .Rst    (Rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .period (period_q),
    .tc     (tc)
  );

  // State register and all output/datapath flops.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= PT_IDLE;
      period_q <= '0;
      rem_q    <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      rem_q    <= rem_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PT_IDLE: begin
        if (accept) begin
          state_d = empty_train ? PT_DONE : PT_RUN;
        end
      end
      PT_RUN: begin
        if (abort) begin
          state_d = PT_IDLE;
        end else if (tc && (rem_q == COUNT_W'(1))) begin
          state_d = PT_DONE;
        end
      end
      PT_DONE: state_d = PT_IDLE;
      default: state_d = PT_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    period_d = period_q;
    rem_d    = rem_q;
    pulse_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      PT_IDLE: begin
        if (accept) begin
          period_d = period;
          rem_d    = count;
          busy_d   = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      PT_RUN: begin
        if (abort) begin
          cnt_clr = 1'b1;
        end else begin
          busy_d = 1'b1;
          cnt_en = 1'b1;
          if (tc) begin
            pulse_d = 1'b1;
            if (rem_q != '0) begin
              rem_d = rem_q - COUNT_W'(1);
            end
          end
        end
      end
      PT_DONE: begin
        // busy stays up through the done cycle and drops one edge later.
        if (!abort) begin
          done_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pulseOut = pulse_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;

  localparam int unsigned PW = 27;
  localparam int unsigned CW = 7;

  logic          Clk;
  logic          Rst;
  logic          start;
  logic [PW-1:0] period;
  logic [CW-1:0] count;
  logic          abort;
  logic          pulseOut;
  logic          busy;
  logic          done;

  int passed = 0;
  int total  = 0;
  int npulse = 0;

  pulse_train_gen #(
    .PERIOD_W (PW),
    .COUNT_W  (CW)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (start),
    .period   (period),
    .count    (count),
    .abort    (abort),
    .pulseOut (pulseOut),
    .busy     (busy),
    .done     (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag, input logic ep, input logic eb, input logic ed);
    check({tag, ".pulseOut"}, int'(pulseOut), int'(ep));
    check({tag, ".busy"}, int'(busy), int'(eb));
    check({tag, ".done"}, int'(done), int'(ed));
  endtask

  // Start accepted at this edge (k); checks the cycle right after it.
  task automatic start_train(input int p, input int n);
    start  = 1'b1;
    period = PW'(p);
    count  = CW'(n);
    tick();
    start  = 1'b0;
    check_outs($sformatf("start p%0d n%0d", p, n), 1'b0, 1'b1, 1'b0);
  endtask

  // Cycles after edges k+j0..k+j1 of a train with period p and n strobes.
  task automatic follow(input int p, input int n, input int j0, input int j1);
    logic ep, eb, ed;
    for (int j = j0; j <= j1; j++) begin
      tick();
      ep = 1'b0;
      if (p != 0 && j <= n * p && (j % p) == 0) ep = 1'b1;
      ed = (j == n * p + 1);
      eb = (j <= n * p + 1);
      if (pulseOut === 1'b1) npulse++;
      check_outs($sformatf("p%0d n%0d j%0d", p, n, j), ep, eb, ed);
    end
  endtask

  initial begin
    Rst    = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    period = '0;
    count  = '0;
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    Rst = 1'b1;
    repeat (7) tick();
    check_outs("idle", 1'b0, 1'b0, 1'b0);

    // P=3, N=4: strobes after k+3,6,9,12, done after k+13, busy low after k+14.
    start_train(3, 4);
    follow(3, 4, 1, 15);

    // P=1, N=100: 100 back-to-back strobes.
    npulse = 0;
    start_train(1, 100);
    follow(1, 100, 1, 102);
    check("p1 strobe count", npulse, 100);

    // Empty trains: done one edge after start, no strobes.
    npulse = 0;
    start_train(5, 0);
    follow(5, 0, 1, 3);
    start_train(0, 5);
    follow(0, 5, 1, 3);
    check("empty strobe count", npulse, 0);

    // Abort after the third strobe of P=4, N=10.
    start_train(4, 10);
    follow(4, 10, 1, 12);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_outs("abort", 1'b0, 1'b0, 1'b0);
    repeat (6) begin
      tick();
      check_outs("post abort", 1'b0, 1'b0, 1'b0);
    end
    start_train(2, 2);
    follow(2, 2, 1, 7);

    // start held through a train with operands changed mid-train.
    start  = 1'b1;
    period = PW'(3);
    count  = CW'(2);
    tick();
    period = PW'(1);
    count  = CW'(5);
    check_outs("held start j0", 1'b0, 1'b1, 1'b0);
    follow(3, 2, 1, 7);
    tick();  // IDLE with start still high: new train accepted here
    start = 1'b0;
    check_outs("held restart", 1'b0, 1'b1, 1'b0);
    follow(1, 5, 1, 8);

    // Reset mid-train after two strobes.
    start_train(5, 8);
    follow(5, 8, 1, 10);
    Rst = 1'b0;
    tick();
    check_outs("mid reset", 1'b0, 1'b0, 1'b0);
    Rst = 1'b1;
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pulseOut === 1'b1) npulse++;
      check_outs("after reset", 1'b0, 1'b0, 1'b0);
    end
    check("after reset strobes", npulse, 0);
    start_train(2, 1);
    follow(2, 1, 1, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
